pipelined_mux_tree: RTL
=======================

PIPELINED_MUX_TREE -- requirements
Module: pipelined_mux_tree

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data bits per channel, WIDTH >= 1.
REQ-002 The block SHALL have parameter SEL_W, default 3: select width, channel count N = 2**SEL_W, SEL_W >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data/sel are valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the input this cycle.
REQ-007 The block SHALL have port sel, input, SEL_W bits: channel index to forward.
REQ-008 The block SHALL have port in_data, input, N*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data/out_sel are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts output this cycle.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: the selected channel data.
REQ-012 The block SHALL have port out_sel, output, SEL_W bits: the sel value that produced out_data.

Function
REQ-013 The block SHALL be a binary 2:1 reduction tree of SEL_W levels, with a register stage after every level.
REQ-014 Level k (k = 1..SEL_W) SHALL reduce N/2**(k-1) entries to N/2**k, pairing entries (2j, 2j+1) and choosing 2j+1 when select bit sel[k-1] = 1, else 2j.
REQ-015 Each stage SHALL carry a valid bit, its reduced data, and the full original sel value for out_sel.
REQ-016 Internal signal advance = out_ready OR NOT out_valid; all stages SHALL shift together exactly when advance = 1 (global stall).
REQ-017 in_ready SHALL equal advance, combinationally; a transfer occurs when in_valid AND in_ready.
REQ-018 On advance with in_valid = 0, stage 1 SHALL load valid = 0 (bubble); the contents of bubble data registers are don't-care.
REQ-019 When advance = 0, every stage register, including out_data, out_sel and out_valid, SHALL hold its value.
REQ-020 Latency SHALL be SEL_W cycles from accepted input to out_valid with no stall; throughput SHALL be one item per cycle.
REQ-021 Output ordering SHALL equal acceptance order; no item may be dropped or duplicated under any out_ready pattern.
REQ-022 The out_data of an item SHALL equal in_data channel sel as sampled at acceptance, independent of later in_data/sel changes.
REQ-023 out_valid SHALL not drop while out_valid = 1 and out_ready = 0, and out_data/out_sel SHALL stay stable in that case.
REQ-024 Simultaneous output pop and input accept SHALL be supported in the same cycle when the pipeline is full.
REQ-025 SEL_W = 1 SHALL yield a single-stage, 1-cycle-latency 2:1 mux with identical handshake.

Reset
REQ-026 On rst_n low, all stage valid bits, out_valid, out_data and out_sel SHALL clear to 0 immediately, without waiting for clk.
REQ-027 Reset mid-operation SHALL discard all in-flight items; none may appear after release.
REQ-028 in_ready SHALL be 1 during and after reset (out_valid = 0).
REQ-029 The first accept after reset SHALL occur on the first rising clk edge with rst_n high.

Verification
REQ-030 Defaults: in_data = 0xF7E6D5C4B3A29180 (channel i = {i+8, i}), stream sel 0..7 every cycle, out_ready = 1 -> out_data 0x80,0x91,...,0xF7 on cycles 3..10, out_sel 0..7.
REQ-031 Backpressure: fill the pipeline, hold out_ready = 0 for 5 cycles -> out_valid stays 1, out_data/out_sel stable, in_ready = 0; release -> remaining items emerge in order, none lost.
REQ-032 Bubbles: in_valid toggles 1,0,1,0 with sel = 5,x,2,x -> out_valid pattern 1,0,1,0 at latency 3 with data 0xD5, 0xA2.
REQ-033 Input change after accept: sel = 6 accepted, then in_data channel 6 changed next cycle -> output carries the value sampled at acceptance.
REQ-034 Reset mid-flight: 3 items in the pipeline, assert rst_n low between clk edges -> out_valid and out_data go 0 at once; no item emitted after release.
REQ-035 Parameter sweep: WIDTH = 1, 16 and SEL_W = 1, 4, random valid/ready over 10000 cycles -> scoreboard matches every output, latency SEL_W with no stall.

Source files
------------

// File: rtl/pipelined_mux_tree.sv
// Pipelined N:1 multiplexer built as a binary tree of 2:1 muxes with a
// register stage after every tree level. All stages advance together under a
// single global stall, so the pipeline behaves like a fixed-latency shift
// register carrying {valid, partially reduced data, original sel}.
module pipelined_mux_tree #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SEL_W-1:0]             sel,
  input  logic [(2**SEL_W)*WIDTH-1:0]  in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [SEL_W-1:0]             out_sel
);

  localparam int N = 1 << SEL_W;

  // Pipeline moves when the output slot is empty or being drained.
  logic advance;

  // Per-stage control: stage k sits after tree level k.
  logic             valid_q [1:SEL_W];
  logic             valid_d [1:SEL_W];
  logic [SEL_W-1:0] sel_q   [1:SEL_W];
  logic [SEL_W-1:0] sel_d   [1:SEL_W];

  // Tree nodes in heap order: node 1 is the root (last stage), node n has
  // children 2n and 2n+1. Children at index >= N are the input channels,
  // so channel i is leaf N+i and level-1 node j pairs channels (2j, 2j+1).
  logic [WIDTH-1:0] node_q [1:N-1];
  logic [WIDTH-1:0] node_d [1:N-1];

  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;
  assign out_valid = valid_q[SEL_W];
  assign out_data  = node_q[1];
  assign out_sel   = sel_q[SEL_W];

  // Stage control next-state: take the upstream stage on advance, else hold.
  for (genvar gi = 1; gi <= SEL_W; gi++) begin : g_stage
    if (gi == 1) begin : g_first
      assign valid_d[gi] = advance ? in_valid : valid_q[gi];
      assign sel_d[gi]   = advance ? sel      : sel_q[gi];
    end else begin : g_rest
      assign valid_d[gi] = advance ? valid_q[gi-1] : valid_q[gi];
      assign sel_d[gi]   = advance ? sel_q[gi-1]   : sel_q[gi];
    end
  end

  // Node next-state: 2:1 pick between the two children using the sel bit
  // belonging to this node's tree level, with the sel travelling alongside.
  for (genvar gi = 1; gi < N; gi++) begin : g_node
    localparam int LVL = SEL_W - $clog2(gi + 1) + 1;
    logic [WIDTH-1:0] lo_w;
    logic [WIDTH-1:0] hi_w;
    logic             pick_w;
    if (LVL == 1) begin : g_leaf
      assign lo_w   = in_data[(2*gi-N)*WIDTH +: WIDTH];
      assign hi_w   = in_data[(2*gi+1-N)*WIDTH +: WIDTH];
      assign pick_w = sel[0];
    end else begin : g_inner
      assign lo_w   = node_q[2*gi];
      assign hi_w   = node_q[2*gi+1];
      assign pick_w = sel_q[LVL-1][LVL-1];
    end
    assign node_d[gi] = advance ? (pick_w ? hi_w : lo_w) : node_q[gi];
  end

  // Stage valid and sel registers; reset empties the whole pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= SEL_W; k++) begin
        valid_q[k] <= 1'b0;
        sel_q[k]   <= '0;
      end
    end else begin
      for (int k = 1; k <= SEL_W; k++) begin
        valid_q[k] <= valid_d[k];
        sel_q[k]   <= sel_d[k];
      end
    end
  end

  // Tree data registers; cleared on reset so out_data reads 0 immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 1; n < N; n++) begin
        node_q[n] <= '0;
      end
    end else begin
      for (int n = 1; n < N; n++) begin
        node_q[n] <= node_d[n];
      end
    end
  end

endmodule
